// File: rtl/dp_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package  : dp_ctrl_pkg
// Brief    : Opcodes, states, ALU codes and control word shared by the sequencer.
// Revision : 1.0
// ============================================================================
package dp_ctrl_pkg;

    localparam logic [1:0] OP_SUB  = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_PASS = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_PASS = 3'b010;
    localparam logic [2:0] ALU_OUT  = 3'b011;

    localparam int HOLD_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_LATCH = 3'd3,
        ST_EXEC  = 3'd4,
        ST_WB    = 3'd5,
        ST_DONE  = 3'd6
    } state_e;

    typedef struct packed {
        logic       clr;
        logic [3:0] ce;
        logic [2:0] w;
        logic [2:0] s;
        logic [1:0] sel;
        logic       done;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_IDLE = '{clr: 1'b0, ce: 4'b0000, w: 3'b000,
                                         s: 3'b000, sel: 2'b11, done: 1'b0};

    function automatic logic [2:0] op_fn(input logic [1:0] op);
        logic [2:0] fn;
        case (op)
            OP_SUB:  fn = ALU_SUB;
            OP_PASS: fn = ALU_PASS;
            default: fn = ALU_ADD;
        endcase
        return fn;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dp_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module   : dp_ctrl_decode
// Brief    : Combinational (state, latched opcode) -> datapath control word.
// Revision : 1.0
// ============================================================================
module dp_ctrl_decode
    import dp_ctrl_pkg::*;
(
    input  state_e     state,
    input  logic [1:0] op,
    output ctrl_word_t ctrl
);

    logic [2:0] fn;

    always_comb begin
        fn   = op_fn(op);
        ctrl = CTRL_IDLE;
        case (state)
            ST_CLR: begin
                ctrl.clr = 1'b1;
            end
            ST_LOAD: begin
                ctrl.ce  = 4'b1111;
                ctrl.s   = ALU_PASS;
                ctrl.sel = 2'b00;
            end
            ST_LATCH: begin
                ctrl.ce  = 4'b1000;
                ctrl.s   = ALU_PASS;
                ctrl.sel = 2'b00;
            end
            ST_EXEC: begin
                ctrl.s   = fn;
                ctrl.sel = 2'b01;
            end
            ST_WB: begin
                ctrl.ce  = 4'b1100;
                ctrl.w   = 3'b100;
                ctrl.s   = fn;
                // PASS writes back the directly loaded operand, not the ALU result
                ctrl.sel = (op == OP_PASS) ? 2'b00 : 2'b01;
            end
            ST_DONE: begin
                ctrl.w    = 3'b100;
                ctrl.s    = ALU_OUT;
                ctrl.done = 1'b1;
            end
            default: ctrl = CTRL_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dp_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dp_op_sequencer
// Brief    : Per-opcode micro-sequencer driving the register/ALU/mux datapath.
// Revision : 1.0
// ============================================================================
module dp_op_sequencer
    import dp_ctrl_pkg::*;
#(
    parameter int unsigned EXEC_HOLD = 1,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic [1:0]       req_op,
    output logic             req_ready,
    input  logic             abort,
    output logic             clr,
    output logic [3:0]       ce,
    output logic [2:0]       w,
    output logic [2:0]       s,
    output logic [1:0]       sel,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] op_count
);

    state_e             state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [1:0]         op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               accept;
    ctrl_word_t         ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            op_q    <= OP_SUB;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE) && !abort;
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        if (abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_d    = req_op;
                        state_d = ST_CLR;
                    end
                end
                ST_CLR:   state_d = (op_q == OP_CLR) ? ST_DONE : ST_LOAD;
                ST_LOAD:  state_d = (op_q == OP_PASS) ? ST_WB : ST_LATCH;
                ST_LATCH: begin
                    state_d = ST_EXEC;
                    hold_d  = HOLD_W'(EXEC_HOLD - 1);
                end
                ST_EXEC: begin
                    if (hold_q == '0) state_d = ST_WB;
                    else              hold_d  = hold_q - 1'b1;
                end
                ST_WB:    state_d = ST_DONE;
                ST_DONE: begin
                    state_d = ST_IDLE;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    dp_ctrl_decode u_decode (
        .state (state_q),
        .op    (op_q),
        .ctrl  (ctrl)
    );

    assign clr      = ctrl.clr;
    assign ce       = ctrl.ce;
    assign w        = ctrl.w;
    assign s        = ctrl.s;
    assign sel      = ctrl.sel;
    assign done     = ctrl.done;
    assign busy     = (state_q != ST_IDLE);
    assign op_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_dp_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dp_op_sequencer
// Brief    : Directed bench over three parameterisations sharing one stimulus.
// Revision : 1.0
// ============================================================================
module tb_dp_op_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic [1:0] req_op;
    logic       abort;

    always #5 clk = ~clk;

    // a: EXEC_HOLD=1 CNT_W=8, b: EXEC_HOLD=3, c: CNT_W=2
    logic       rdy_a, rdy_b, rdy_c;
    logic       clr_a, clr_b, clr_c;
    logic [3:0] ce_a, ce_b, ce_c;
    logic [2:0] w_a, w_b, w_c;
    logic [2:0] s_a, s_b, s_c;
    logic [1:0] sel_a, sel_b, sel_c;
    logic       busy_a, busy_b, busy_c;
    logic       done_a, done_b, done_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;

    dp_op_sequencer #(.EXEC_HOLD(1), .CNT_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
        .req_ready(rdy_a), .abort(abort), .clr(clr_a), .ce(ce_a), .w(w_a),
        .s(s_a), .sel(sel_a), .busy(busy_a), .done(done_a), .op_count(cnt_a));

    dp_op_sequencer #(.EXEC_HOLD(3), .CNT_W(8)) u_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
        .req_ready(rdy_b), .abort(abort), .clr(clr_b), .ce(ce_b), .w(w_b),
        .s(s_b), .sel(sel_b), .busy(busy_b), .done(done_b), .op_count(cnt_b));

    dp_op_sequencer #(.EXEC_HOLD(1), .CNT_W(2)) u_c (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
        .req_ready(rdy_c), .abort(abort), .clr(clr_c), .ce(ce_c), .w(w_c),
        .s(s_c), .sel(sel_c), .busy(busy_c), .done(done_c), .op_count(cnt_c));

    logic [31:0] word_a, word_b, word_c;
    assign word_a = {17'd0, clr_a, ce_a, w_a, s_a, sel_a, done_a, busy_a};
    assign word_b = {17'd0, clr_b, ce_b, w_b, s_b, sel_b, done_b, busy_b};
    assign word_c = {17'd0, clr_c, ce_c, w_c, s_c, sel_c, done_c, busy_c};

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [31:0] mk(input int c, input int e, input int wv,
                                       input int sv, input int sl, input int d,
                                       input int b);
        logic [31:0] r;
        r = {17'd0, c[0], e[3:0], wv[2:0], sv[2:0], sl[1:0], d[0], b[0]};
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'b00;
        abort     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    logic [31:0] IDLE_W, CLR_W, LOAD_W, LATCH_W, DONE_W;
    logic [31:0] wrap_exp [4];

    initial begin
        IDLE_W  = mk(0, 4'h0, 0, 0, 3, 0, 0);
        CLR_W   = mk(1, 4'h0, 0, 0, 3, 0, 1);
        LOAD_W  = mk(0, 4'hF, 0, 2, 0, 0, 1);
        LATCH_W = mk(0, 4'h8, 0, 2, 0, 0, 1);
        DONE_W  = mk(0, 4'h0, 4, 3, 3, 1, 1);
        wrap_exp[0] = 32'd1; wrap_exp[1] = 32'd2; wrap_exp[2] = 32'd3; wrap_exp[3] = 32'd0;

        // SUB, EXEC_HOLD=1
        do_reset();
        chk("reset_word", word_a, IDLE_W);
        chk("reset_cnt", 32'(cnt_a), 32'd0);
        chk("reset_ready", 32'(rdy_a), 32'd1);
        req_valid = 1'b1; req_op = 2'b00;
        tick();
        req_valid = 1'b0;
        chk("sub_c1_clr", word_a, CLR_W);
        tick(); chk("sub_c2_load", word_a, LOAD_W);
        tick(); chk("sub_c3_latch", word_a, LATCH_W);
        tick(); chk("sub_c4_exec", word_a, mk(0, 4'h0, 0, 1, 1, 0, 1));
        tick(); chk("sub_c5_wb", word_a, mk(0, 4'hC, 4, 1, 1, 0, 1));
        tick(); chk("sub_c6_done", word_a, DONE_W);
        tick(); chk("sub_c7_idle", word_a, IDLE_W);
        chk("sub_cnt", 32'(cnt_a), 32'd1);

        // ADD, EXEC_HOLD=3
        do_reset();
        req_valid = 1'b1; req_op = 2'b01;
        tick();
        req_valid = 1'b0;
        chk("add_c1_clr", word_b, CLR_W);
        tick(); chk("add_c2_load", word_b, LOAD_W);
        tick(); chk("add_c3_latch", word_b, LATCH_W);
        tick(); chk("add_c4_exec", word_b, mk(0, 4'h0, 0, 0, 1, 0, 1));
        tick(); chk("add_c5_exec", word_b, mk(0, 4'h0, 0, 0, 1, 0, 1));
        tick(); chk("add_c6_exec", word_b, mk(0, 4'h0, 0, 0, 1, 0, 1));
        tick(); chk("add_c7_wb", word_b, mk(0, 4'hC, 4, 0, 1, 0, 1));
        tick(); chk("add_c8_done", word_b, DONE_W);
        tick(); chk("add_cnt", 32'(cnt_b), 32'd1);

        // asynchronous reset in the middle of EXEC
        req_valid = 1'b1; req_op = 2'b01;
        tick();
        req_valid = 1'b0;
        tick(); tick(); tick();
        chk("rst_pre_exec", word_b, mk(0, 4'h0, 0, 0, 1, 0, 1));
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_word", word_b, IDLE_W);
        chk("rst_mid_cnt", 32'(cnt_b), 32'd0);
        chk("rst_mid_ready", 32'(rdy_b), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();

        // PASS then CLEAR back-to-back with req_valid held
        do_reset();
        req_valid = 1'b1; req_op = 2'b10;
        tick();
        req_op = 2'b11;
        chk("pass_c1_clr", word_a, CLR_W);
        tick(); chk("pass_c2_load", word_a, LOAD_W);
        chk("pass_busy_ready", 32'(rdy_a), 32'd0);
        tick(); chk("pass_c3_wb", word_a, mk(0, 4'hC, 4, 2, 0, 0, 1));
        tick(); chk("pass_c4_done", word_a, DONE_W);
        tick(); chk("pass_c5_idle", word_a, IDLE_W);
        chk("pass_c5_ready", 32'(rdy_a), 32'd1);
        tick();
        req_valid = 1'b0;
        chk("clear_c6_clr", word_a, CLR_W);
        tick(); chk("clear_c7_done", word_a, DONE_W);
        tick(); chk("clear_c8_idle", word_a, IDLE_W);
        chk("b2b_cnt", 32'(cnt_a), 32'd2);

        // abort in LATCH, then accept, then abort while idle
        do_reset();
        req_valid = 1'b1; req_op = 2'b00;
        tick();
        req_valid = 1'b0;
        tick(); tick();
        chk("abort_latch", word_a, LATCH_W);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_idle_word", word_a, IDLE_W);
        chk("abort_cnt", 32'(cnt_a), 32'd0);
        req_valid = 1'b1; req_op = 2'b11;
        tick();
        req_valid = 1'b0;
        chk("abort_reaccept", word_a, CLR_W);
        tick(); chk("abort_re_done", word_a, DONE_W);
        tick(); chk("abort_re_cnt", 32'(cnt_a), 32'd1);
        abort = 1'b1; req_valid = 1'b1; req_op = 2'b00;
        #1;
        chk("idle_abort_ready", 32'(rdy_a), 32'd0);
        tick();
        abort = 1'b0; req_valid = 1'b0;
        chk("idle_abort_noacc", word_a, IDLE_W);
        tick();
        chk("idle_abort_cnt", 32'(cnt_a), 32'd1);

        // counter wrap with CNT_W=2
        do_reset();
        req_valid = 1'b1; req_op = 2'b11;
        for (int i = 0; i < 4; i++) begin
            tick();
            tick();
            chk("wrap_done", 32'(done_c), 32'd1);
            tick();
            chk("wrap_cnt", 32'(cnt_c), wrap_exp[i]);
        end
        req_valid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
